// File: rtl/monociclo_trace_pkg.sv
// rtl/monociclo_trace_pkg.sv - shared types and constants for the monociclo run/trace controller
package monociclo_trace_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE = 2'd0,
        TRC_RST  = 2'd1,
        TRC_RUN  = 2'd2,
        TRC_DONE = 2'd3
    } trc_state_t;

    localparam logic TRC_MODE_ALL = 1'b0;
    localparam logic TRC_MODE_CHG = 1'b1;

    localparam int TRC_DATA_W = 32;
    localparam int TRC_DEPTH  = 16;
    localparam int TRC_TS_W   = 16;

endpackage

// File: rtl/monociclo_trace_if.sv
// rtl/monociclo_trace_if.sv - control, core and trace-read signals of the controller (MONOCICLO_TRACE_TS_EN adds rd_ts_o)
interface monociclo_trace_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              start_i;
    logic              mode_i;
    logic [DATA_W-1:0] core_out_i;
    logic              core_rst_no;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  cycle_o;
    logic [AW:0]       count_o;
    logic              overflow_o;
    logic [AW-1:0]     rd_idx_i;
    logic [DATA_W-1:0] rd_data_o;
`ifdef MONOCICLO_TRACE_TS_EN
    logic [15:0]       rd_ts_o;
`endif

    modport master (
        output start_i, mode_i, core_out_i, rd_idx_i,
        input  core_rst_no, busy_o, done_o, cycle_o, count_o, overflow_o, rd_data_o
`ifdef MONOCICLO_TRACE_TS_EN
        , rd_ts_o
`endif
    );

    modport slave (
        input  start_i, mode_i, core_out_i, rd_idx_i,
        output core_rst_no, busy_o, done_o, cycle_o, count_o, overflow_o, rd_data_o
`ifdef MONOCICLO_TRACE_TS_EN
        , rd_ts_o
`endif
    );

endinterface

// File: rtl/monociclo_trace_ctrl_ring.sv
// rtl/monociclo_trace_ctrl_ring.sv - circular trace buffer with oldest-relative registered read
module trace_ring #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              overflow
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rd_addr;
    logic              full;

    assign full    = (count == (AW+1)'(DEPTH));
    // When full, count's low bits are zero so wp itself is the oldest slot.
    assign rd_addr = wp - count[AW-1:0] + rd_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (wr_en) begin
            wp <= wp + 1'b1;
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if ({1'b0, rd_idx} < count) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/monociclo_trace_ctrl.sv
// rtl/monociclo_trace_ctrl.sv - core reset sequencer, bounded run and trace capture (MONOCICLO_TRACE_TS_EN adds timestamps)
module monociclo_trace_ctrl
    import monociclo_trace_pkg::*;
#(
    parameter int DATA_W     = TRC_DATA_W,
    parameter int DEPTH      = TRC_DEPTH,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 60,
    parameter int CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    monociclo_trace_if.slave     bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(RST_CYCLES + 1);
`ifdef MONOCICLO_TRACE_TS_EN
    localparam int WORD_W = DATA_W + TRC_TS_W;
`else
    localparam int WORD_W = DATA_W;
`endif

    trc_state_t        state, state_nxt;
    logic [RW-1:0]     rst_cnt;
    logic [CNT_W-1:0]  cycle;
    logic              mode_q;
    logic [DATA_W-1:0] last;
    logic              last_vld;
    logic              start_ok;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] ring_rd;
    logic [AW:0]       ring_count;
    logic              ring_ovf;

    assign start_ok = bus.start_i && (state == TRC_IDLE || state == TRC_DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= TRC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TRC_IDLE, TRC_DONE: if (start_ok) state_nxt = TRC_RST;
            TRC_RST:  if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = TRC_RUN;
            TRC_RUN:  if (cycle == CNT_W'(MAX_CYCLES - 1)) state_nxt = TRC_DONE;
            default:  state_nxt = TRC_IDLE;
        endcase
    end

    always_comb begin
        bus.core_rst_no = 1'b0;
        bus.busy_o      = 1'b0;
        bus.done_o      = 1'b0;
        case (state)
            TRC_RST:  bus.busy_o = 1'b1;
            TRC_RUN: begin
                bus.busy_o      = 1'b1;
                bus.core_rst_no = 1'b1;
            end
            TRC_DONE: bus.done_o = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_cnt  <= '0;
            cycle    <= '0;
            mode_q   <= TRC_MODE_ALL;
            last     <= '0;
            last_vld <= 1'b0;
        end else begin
            if (start_ok) begin
                rst_cnt  <= '0;
                cycle    <= '0;
                mode_q   <= bus.mode_i;
                last_vld <= 1'b0;
            end
            if (state == TRC_RST) begin
                rst_cnt <= rst_cnt + 1'b1;
            end
            if (state == TRC_RUN) begin
                cycle    <= cycle + 1'b1;
                last     <= bus.core_out_i;
                last_vld <= 1'b1;
            end
        end
    end

    // Change mode compares against the previous sample, written or not.
    assign wr_en = (state == TRC_RUN) &&
                   (mode_q == TRC_MODE_ALL || !last_vld || bus.core_out_i != last);

`ifdef MONOCICLO_TRACE_TS_EN
    assign wr_data = {TRC_TS_W'(cycle), bus.core_out_i};
`else
    assign wr_data = bus.core_out_i;
`endif

    trace_ring #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk      (clk_i),
        .rst      (rst_i),
        .clr      (start_ok),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_idx   (bus.rd_idx_i),
        .rd_data  (ring_rd),
        .count    (ring_count),
        .overflow (ring_ovf)
    );

    assign bus.cycle_o    = cycle;
    assign bus.count_o    = ring_count;
    assign bus.overflow_o = ring_ovf;
    assign bus.rd_data_o  = ring_rd[DATA_W-1:0];
`ifdef MONOCICLO_TRACE_TS_EN
    assign bus.rd_ts_o    = ring_rd[WORD_W-1:DATA_W];
`endif

endmodule

// File: tb/tb_monociclo_trace_ctrl.sv
// tb/tb_monociclo_trace_ctrl.sv - directed table-driven bench for monociclo_trace_ctrl (MONOCICLO_TRACE_TS_EN checks rd_ts_o)
module tb_monociclo_trace_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] core_out = '0;
    logic [3:0]  rd_idx = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [15:0] exp_ts;
    } rd_vec_t;

    rd_vec_t wrap_tbl [6];
    rd_vec_t chg_tbl  [4];
    logic [31:0] chg_pat [6];

    always #5 clk = ~clk;

    monociclo_trace_if #(.DATA_W(32), .DEPTH(16), .CNT_W(16)) ifa ();
    monociclo_trace_if #(.DATA_W(32), .DEPTH(16), .CNT_W(16)) ifb ();

    assign ifa.start_i    = start;
    assign ifa.mode_i     = mode;
    assign ifa.core_out_i = core_out;
    assign ifa.rd_idx_i   = rd_idx;
    assign ifb.start_i    = start;
    assign ifb.mode_i     = mode;
    assign ifb.core_out_i = core_out;
    assign ifb.rd_idx_i   = rd_idx;

    monociclo_trace_ctrl #(.DATA_W(32), .DEPTH(16), .RST_CYCLES(2), .MAX_CYCLES(10), .CNT_W(16))
        u_dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    monociclo_trace_ctrl #(.DATA_W(32), .DEPTH(16), .RST_CYCLES(2), .MAX_CYCLES(20), .CNT_W(16))
        u_dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic m);
        start = 1'b1;
        mode  = m;
        core_out = '0;
        tick();
        start = 1'b0;
        mode  = ~m;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        wrap_tbl[0] = '{4'd0,  32'd1,  32'd5,  16'd0};
        wrap_tbl[1] = '{4'd1,  32'd2,  32'd6,  16'd0};
        wrap_tbl[2] = '{4'd5,  32'd6,  32'd10, 16'd0};
        wrap_tbl[3] = '{4'd9,  32'd10, 32'd14, 16'd0};
        wrap_tbl[4] = '{4'd10, 32'd0,  32'd15, 16'd0};
        wrap_tbl[5] = '{4'd15, 32'd0,  32'd20, 16'd0};
        chg_tbl[0]  = '{4'd0,  32'd7,  32'd7,  16'd0};
        chg_tbl[1]  = '{4'd1,  32'd9,  32'd9,  16'd3};
        chg_tbl[2]  = '{4'd2,  32'd7,  32'd7,  16'd5};
        chg_tbl[3]  = '{4'd3,  32'd0,  32'd0,  16'd0};
        chg_pat     = '{32'd7, 32'd7, 32'd7, 32'd9, 32'd9, 32'd7};

        // Reset state
        tick();
        tick();
        check("rst_core_rst_no", ifa.core_rst_no, 0);
        check("rst_busy",        ifa.busy_o,      0);
        check("rst_done",        ifa.done_o,      0);
        check("rst_cycle",       ifa.cycle_o,     0);
        check("rst_count",       ifa.count_o,     0);
        check("rst_overflow",    ifa.overflow_o,  0);
        check("rst_rd_data",     ifa.rd_data_o,   0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("idle_busy",        ifa.busy_o,      0);
        check("idle_core_rst_no", ifa.core_rst_no, 0);
        check("idle_done",        ifa.done_o,      0);

        // Mode 0 counting run; A stops at 10, B wraps at 20
        start_run(1'b0);
        check("m0_busy_a",        ifa.busy_o,      1);
        check("m0_busy_b",        ifb.busy_o,      1);
        check("m0_hold0_rst_no",  ifa.core_rst_no, 0);
        tick();
        check("m0_hold1_rst_no",  ifa.core_rst_no, 0);
        tick();
        check("m0_run_rst_no",    ifa.core_rst_no, 1);
        for (int k = 1; k <= 20; k++) begin
            core_out = 32'(k);
            start = (k == 5);
            tick();
            start = 1'b0;
            if (k == 9)  check("m0_a_done_early", ifa.done_o, 0);
            if (k == 10) begin
                check("m0_a_done",      ifa.done_o,      1);
                check("m0_a_rst_no",    ifa.core_rst_no, 0);
                check("m0_a_cycle",     ifa.cycle_o,     10);
            end
            if (k == 19) check("m0_b_done_early", ifb.done_o, 0);
        end
        check("m0_b_done",     ifb.done_o,     1);
        check("m0_b_busy",     ifb.busy_o,     0);
        check("m0_b_cycle",    ifb.cycle_o,    20);
        check("m0_a_cycle_hold", ifa.cycle_o,  10);
        check("m0_a_count",    ifa.count_o,    10);
        check("m0_a_overflow", ifa.overflow_o, 0);
        check("wrap_b_count",  ifb.count_o,    16);
        check("wrap_b_overflow", ifb.overflow_o, 1);
        for (int i = 0; i < 6; i++) begin
            rd_idx = wrap_tbl[i].idx;
            tick();
            check($sformatf("m0_a_rd%0d", wrap_tbl[i].idx), ifa.rd_data_o, wrap_tbl[i].exp_a);
            check($sformatf("wrap_b_rd%0d", wrap_tbl[i].idx), ifb.rd_data_o, wrap_tbl[i].exp_b);
        end

        // Restart from DONE in change mode; mode input flips after the start edge
        start_run(1'b1);
        check("m1_count_clr_b",  ifb.count_o,     0);
        check("m1_ovf_clr_b",    ifb.overflow_o,  0);
        check("m1_cycle_clr_a",  ifa.cycle_o,     0);
        check("m1_hold0_rst_no", ifb.core_rst_no, 0);
        tick();
        check("m1_hold1_rst_no", ifb.core_rst_no, 0);
        tick();
        check("m1_run_rst_no",   ifb.core_rst_no, 1);
        for (int k = 0; k < 20; k++) begin
            core_out = (k < 6) ? chg_pat[k] : 32'd7;
            tick();
        end
        check("m1_a_done",  ifa.done_o,  1);
        check("m1_b_done",  ifb.done_o,  1);
        check("m1_a_count", ifa.count_o, 3);
        check("m1_b_count", ifb.count_o, 3);
        for (int i = 0; i < 4; i++) begin
            rd_idx = chg_tbl[i].idx;
            tick();
            check($sformatf("m1_a_rd%0d", chg_tbl[i].idx), ifa.rd_data_o, chg_tbl[i].exp_a);
            check($sformatf("m1_b_rd%0d", chg_tbl[i].idx), ifb.rd_data_o, chg_tbl[i].exp_b);
`ifdef MONOCICLO_TRACE_TS_EN
            check($sformatf("m1_a_ts%0d", chg_tbl[i].idx), ifa.rd_ts_o, chg_tbl[i].exp_ts);
`endif
        end

        // Abort mid-run at cycle 4
        rd_idx = 4'd0;
        start_run(1'b0);
        tick();
        tick();
        for (int k = 1; k <= 4; k++) begin
            core_out = 32'(100 + k);
            tick();
        end
        check("ab_cycle",  ifa.cycle_o, 4);
        check("ab_count",  ifa.count_o, 4);
        check("ab_rd0",    ifa.rd_data_o, 101);
        rst = 1'b1;
        tick();
        check("ab_busy",    ifa.busy_o,      0);
        check("ab_rst_no",  ifa.core_rst_no, 0);
        check("ab_count0",  ifa.count_o,     0);
        check("ab_cycle0",  ifa.cycle_o,     0);
        check("ab_rd_data", ifa.rd_data_o,   0);
        rst = 1'b0;
        tick();
        tick();
        check("ab_idle_busy",  ifa.busy_o,    0);
        check("ab_idle_done",  ifa.done_o,    0);
        check("ab_idle_rd",    ifa.rd_data_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/monociclo_trace_ctrl.md
# monociclo_trace_ctrl

Synthesizable run controller and trace recorder for the single-cycle core (`monociclo`).
- Sequences the core's active-low reset for a configurable number of cycles.
- Lets the core run for a bounded number of cycles, then freezes it.
- Records the core's output word into a circular trace buffer, either every cycle or on change.
- Sits between the core and the board or bench, and replaces free-running clock/reset stimulus with a repeatable, readable run.

## Interface
- `DATA_W`, 32, width of core output and trace words
- `DEPTH`, 16, trace entries; power of two, ≥2
- `RST_CYCLES`, 2, cycles core reset is held low per run; ≥1
- `MAX_CYCLES`, 60, run length in core cycles; ≥1
- `CNT_W`, 16, cycle counter width; 2^CNT_W > MAX_CYCLES

- `clk_i` in 1: sole clock, rising edge
- `rst_i` in 1: asynchronous, active-high reset
- `start_i` in 1: start run; sampled in IDLE or DONE only
- `mode_i` in 1: 0 = capture every RUN cycle, 1 = capture only on change; latched at start
- `core_out_i` in DATA_W: core `salida_o`
- `core_rst_no` out 1: drives core `rst_ni`
- `busy_o` out 1: high in RESET_HOLD or RUN
- `done_o` out 1: high in DONE
- `cycle_o` out CNT_W: RUN cycles elapsed
- `count_o` out $clog2(DEPTH)+1: valid entries, saturates at DEPTH
- `overflow_o` out 1: sticky, set when an entry was overwritten
- `rd_idx_i` in $clog2(DEPTH): 0 = oldest valid entry
- `rd_data_o` out DATA_W: trace word at `rd_idx_i`, registered

## Operation
- FSM states: IDLE, RESET_HOLD, RUN, DONE.
- Reset (`rst_i` high) forces IDLE and sets every output to 0, `core_rst_no` included. `rst_i` mid-run aborts the run immediately and the trace is lost.
- **IDLE:** `core_rst_no`=0. On `start_i`=1:
  - clear write pointer, count, overflow, cycle counter and change-tracker valid flag;
  - latch `mode_i`;
  - go to RESET_HOLD.
- **RESET_HOLD:** `core_rst_no`=0 for exactly RST_CYCLES cycles, then RUN.
- **RUN:** `core_rst_no`=1.
  - Each cycle, sample `core_out_i` and increment `cycle_o`.
  - Leave for DONE on the edge where `cycle_o` reaches MAX_CYCLES.
  - `start_i` is ignored in RESET_HOLD and RUN.
- **DONE:** `core_rst_no`=0, so the core is frozen. Trace and counters are held and stay readable. `start_i` begins a new run (same actions as from IDLE).
- **Capture:** on RUN edges only.
  - Mode 0 writes every sample.
  - Mode 1 writes when the tracker is not valid (first RUN sample is always written) or when the sample differs from the last sample seen.
- **Buffer:** circular.
  - Write at `wp`, then `wp`+1 mod DEPTH; `count` increments up to DEPTH.
  - A write with `count`==DEPTH overwrites the oldest entry and sets `overflow_o`.
- **Read:** physical address = (`wp` − `count` + `rd_idx_i`) mod DEPTH.
  - `rd_idx_i` ≥ `count` returns 0.
  - Reads are allowed in any state. A read in the same cycle as a write returns pre-write contents.

## Timing
- `rd_data_o` valid one cycle after `rd_idx_i` changes.
- `start_i` edge to `busy_o`=1: 1 cycle.
- `core_rst_no` rises RST_CYCLES cycles after `busy_o` rises.
- First capture happens on the first RUN edge, i.e. the core's first post-reset output.
- `done_o` rises MAX_CYCLES cycles after `core_rst_no` rises. `core_rst_no` falls on that same edge.
- `cycle_o`, `count_o` and `overflow_o` update on the capture edge and are visible the following cycle.

## Configuration
- `MONOCICLO_TRACE_TS_EN` defined: each entry also stores the 16-bit `cycle_o` value at capture time.
  - This value is exposed on an extra output `rd_ts_o` (16 bits) with the same read latency and out-of-range rule as `rd_data_o`.
  - Intended for mode 1, where entries are sparse.
- Not defined: no timestamp storage and no `rd_ts_o` port.

## Structure
- Shared package `monociclo_trace_pkg`:
  - FSM state enum (`TRC_IDLE`, `TRC_RST`, `TRC_RUN`, `TRC_DONE`);
  - mode constants `TRC_MODE_ALL`=0 and `TRC_MODE_CHG`=1;
  - default DATA_W / DEPTH.
- Sub-module `trace_ring`: DEPTH×(DATA_W[+16]) register array with write pointer, count, overflow and oldest-relative registered read.
- Top level keeps the FSM, counters and change detector.

## Test plan
- **Reset:** `rst_i`=1 → all outputs 0. Release, no start, 20 cycles → still IDLE, `core_rst_no`=0.
- **Mode 0:** `start_i` pulse, counting pattern 1,2,3… on `core_out_i`, MAX_CYCLES=10, DEPTH=16 → 10 entries, `rd_idx_i`=0..9 reads 1..10, `done_o`=1, `overflow_o`=0.
- **Wrap:** same pattern, MAX_CYCLES=20, DEPTH=16 → `count_o`=16, `overflow_o`=1, `rd_idx_i`=0 reads 5, 15 reads 20.
- **Mode 1:** input 7,7,7,9,9,7 → 3 entries: 7, 9, 7. With `MONOCICLO_TRACE_TS_EN`, `rd_ts_o` = 0, 3, 5.
- **Abort:** `rst_i` asserted mid-RUN at cycle 4 → next cycle IDLE, `count_o`=0, `core_rst_no`=0.
- **Restart and ignored start:** `start_i` during RUN is ignored. `start_i` in DONE → trace cleared, RESET_HOLD lasts exactly RST_CYCLES cycles.
